adv_room_fsm: RTL

Room-navigation state machine for the adventure-game datapath. Tracks the player's room from four direction buttons and drives `sw` high while the player is in the Secret Sword Stash; that signal feeds `sword_fsm`. It consumes `sword_fsm`'s `v` output to resolve the Dragon's Den encounter into a win or a death. Both terminal states are sticky until reset.

---
 rtl/adv_pkg.sv | 24 ++
 rtl/adv_room_fsm_btn_edge.sv | 23 ++
 rtl/adv_room_fsm.sv | 79 +++++++
 3 files changed

// File: rtl/adv_pkg.sv
// Shared adventure-game types: room encodings and one-hot direction constants.
package adv_pkg;

  typedef enum logic [2:0] {
    CC  = 3'd0,
    TT  = 3'd1,
    RR  = 3'd2,
    SSS = 3'd3,
    DD  = 3'd4,
    VV  = 3'd5,
    GG  = 3'd6
  } room_t;

  // Button vector order is {n, s, e, w}
  localparam logic [3:0] DIR_N = 4'b1000;
  localparam logic [3:0] DIR_S = 4'b0100;
  localparam logic [3:0] DIR_E = 4'b0010;
  localparam logic [3:0] DIR_W = 4'b0001;

  function automatic logic onehot4(input logic [3:0] x);
    return (x != 4'b0000) && ((x & (x - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/adv_room_fsm_btn_edge.sv
// Button front end: two-flop synchronizer, previous-value flop, rising-edge press.
module btn_edge #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] btn,
  output logic [W-1:0] press
);

  logic [W-1:0] sync1, sync2, prev;

  // The synchronizer keeps sampling through reset so that prev can track a
  // held button; a button already down when reset drops yields no press.
  always_ff @(posedge clk) begin
    sync1 <= btn;
    sync2 <= sync1;
    prev  <= sync2;
  end

  assign press = reset ? '0 : (sync2 & ~prev);

endmodule

// File: rtl/adv_room_fsm.sv
// Room-navigation FSM: button moves between rooms, Dragon's Den resolves on v.
module adv_room_fsm
  import adv_pkg::*;
#(
  parameter int MOVES_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               n,
  input  logic               s,
  input  logic               e,
  input  logic               w,
  input  logic               v,
  output logic               sw,
  output logic [2:0]         room,
  output logic               win,
  output logic               die,
  output logic [MOVES_W-1:0] moves
);

  logic [3:0]         press;
  room_t              state_q, state_d;
  logic               inc;
  logic [MOVES_W-1:0] moves_q;

  btn_edge #(.W(4)) u_btn (
    .clk   (clk),
    .reset (reset),
    .btn   ({n, s, e, w}),
    .press (press)
  );

  always_comb begin
    logic single;
    single  = onehot4(press);
    state_d = state_q;
    inc     = 1'b0;
    case (state_q)
      CC: begin
        if (single && press == DIR_E) state_d = TT;
      end
      TT: begin
        if (single && press == DIR_W)      state_d = CC;
        else if (single && press == DIR_S) state_d = RR;
      end
      RR: begin
        if (single && press == DIR_N)      state_d = TT;
        else if (single && press == DIR_W) state_d = SSS;
        else if (single && press == DIR_E) state_d = DD;
      end
      SSS: begin
        if (single && press == DIR_E) state_d = RR;
      end
      DD:      state_d = v ? VV : GG;
      VV, GG:  state_d = state_q;
      default: state_d = CC;
    endcase
    // Recovery from the illegal code is not a player move
    if (state_q != VV && state_q != GG && state_q inside {CC, TT, RR, SSS, DD})
      inc = (state_d != state_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CC;
      moves_q <= '0;
    end else begin
      state_q <= state_d;
      if (inc && moves_q != '1) moves_q <= moves_q + 1'b1;
    end
  end

  assign room  = state_q;
  assign sw    = (state_q == SSS);
  assign win   = (state_q == VV);
  assign die   = (state_q == GG);
  assign moves = moves_q;

endmodule
